register_datapath: RTL
======================

Name: register_datapath

Overview:
- Datapath that executes the control word issued each cycle by the CPU control unit.
- Holds AR, PC, DR, AC, IR and TR, with per-register load, clear and increment.
- Contains the 3-bit-selected common bus, the memory port and a registered ALU stage.
- Feeds IR back to the control unit and drives the external memory.

Parameters:
- ADDR_WIDTH, 8: width of AR, PC and the memory address.
- DATA_WIDTH, 8: width of DR, AC, IR, TR, the bus and memory data.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- load_AR, load_PC, load_DR, load_AC, load_IR, load_TR  in  1 each  load strobes.
- clear_AR, clear_PC, clear_DR, clear_AC, clear_TR  in  1 each  clear strobes.
- inc_AR, inc_PC, inc_DR, inc_AC, inc_TR  in  1 each  increment strobes.
- memory_read  in  1  memory read enable.
- memory_write  in  1  memory write request.
- bus_selectors  in  3  bus source select.
- alu_enable  in  1  capture the ALU result this cycle.
- alu_mode  in  3  ALU operation.
- mem_rdata  in  DATA_WIDTH  memory read data, combinational w.r.t. mem_addr.
- mem_addr  out  ADDR_WIDTH  equals AR.
- mem_wdata  out  DATA_WIDTH  equals the bus value.
- mem_we  out  1  memory write enable.
- IR  out  DATA_WIDTH  instruction register, to the control unit.
- AC_out  out  DATA_WIDTH  accumulator.
- bus_value  out  DATA_WIDTH  current bus value.
- carry  out  1  E flag.
- zero  out  1  high when AC == 0.
- write_collision  out  1  sticky error flag.

Behaviour:
- Reset, synchronous: AR, PC, DR, AC, IR, TR, the ALU result register, carry and write_collision all go to 0. zero is 1 and mem_we is 0 during reset. Reset overrides every strobe in the same cycle.
- Bus mux, combinational. bus_selectors selects:
  - 0: zero
  - 1: AR, zero-extended
  - 2: PC, zero-extended
  - 3: DR
  - 4: AC
  - 5: IR
  - 6: TR
  - 7: mem_rdata when memory_read = 1, else zero
- Register update priority, per register: clear > load > inc > hold.
  - A load takes the bus value. AR and PC take bus[ADDR_WIDTH-1:0].
  - IR has no clear or inc; it holds unless load_IR is high.
  - Increment wraps modulo 2^width (e.g. PC 0xFF -> 0x00). An increment has no effect on carry.
- A register may load its own bus value (e.g. AR with sel 1); the result is the unchanged value. Multiple registers may load from the bus in the same cycle.
- mem_we = memory_write & ~reset & (bus_selectors != 7), combinational, with zero latency.
- memory_write with bus_selectors == 7 is suppressed and sets write_collision on the next edge. write_collision stays set until reset.
- ALU stage:
  - When alu_enable = 1, the ALU result register and carry capture at the edge. Otherwise they hold.
  - Operands are AC and DR, with DATA_WIDTH+1-bit arithmetic.
  - 000 AND: AC & DR, carry held.
  - 001 ADD: AC + DR, carry = bit DATA_WIDTH.
  - 010 SUB: AC + ~DR + 1, carry = no-borrow.
  - 011 OR: carry held.
  - 100 XOR: carry held.
  - 101 STORE: AC passed through, carry held.
  - 110 LOAD: DR passed through, carry held.
  - 111 NOT: ~AC, carry held.
- AC source: load_AC loads AC from the ALU result register, not from the bus. Latency from alu_enable to the AC update is 2 edges (capture, then load).
- Simultaneous alu_enable and load_AC: AC takes the previous ALU result register value (register-read semantics).
- zero is combinational from AC.
- No internal state machine beyond the registers. Mid-operation reset returns everything to the reset values with no partial writes (mem_we low in that cycle).

Decomposition:
- Shared package (cpu_pkg), used by both the control unit and this block:
  - bus select constants BUS_NONE=0, BUS_AR=1, BUS_PC=2, BUS_DR=3, BUS_AC=4, BUS_IR=5, BUS_TR=6, BUS_MEM=7;
  - ALU mode constants ALU_AND … ALU_NOT;
  - the width defaults.
- One natural sub-module, datapath_register: parameterised width, with clear/load/inc priority. It is instantiated for AR, PC, DR, AC and TR.

Test Plan:
- Reset with all strobes high: after the edge all registers are 0, zero=1, mem_we=0, write_collision=0.
- PC=0x05, sel=2, load_AR, then the next cycle sel=7, load_IR, inc_PC with mem_rdata=0x9A: AR=0x05, IR=0x9A, PC=0x06.
- PC=0xFF, inc_PC: PC=0x00, carry unchanged. clear_TR with load_TR and inc_TR together: TR=0x00.
- AC=0xF0, DR=0x20, alu_mode=001, alu_enable, then load_AC: AC=0x10, carry=1, zero=0. Then mode 010 with DR=0x10: AC=0x00, carry=1, zero=1.
- sel=4, memory_write=1, AC=0x3C, AR=0x12: mem_we=1 in that cycle, mem_addr=0x12, mem_wdata=0x3C.
- memory_write=1 with sel=7: mem_we=0. write_collision=1 after the edge and stays 1 until reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU control unit and the register datapath.
//   - default address/data widths
//   - common-bus source select codes (bus_sel_e)
//   - ALU operation codes (alu_mode_e)
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam int ADDR_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 8;

   typedef enum logic [2:0] {
      BUS_NONE = 3'd0,
      BUS_AR   = 3'd1,
      BUS_PC   = 3'd2,
      BUS_DR   = 3'd3,
      BUS_AC   = 3'd4,
      BUS_IR   = 3'd5,
      BUS_TR   = 3'd6,
      BUS_MEM  = 3'd7
   } bus_sel_e;

   typedef enum logic [2:0] {
      ALU_AND   = 3'd0,
      ALU_ADD   = 3'd1,
      ALU_SUB   = 3'd2,
      ALU_OR    = 3'd3,
      ALU_XOR   = 3'd4,
      ALU_STORE = 3'd5,
      ALU_LOAD  = 3'd6,
      ALU_NOT   = 3'd7
   } alu_mode_e;

endpackage

// File: rtl/datapath_register.sv
// ----------------------------------------------------------------------------
// datapath_register
// One general-purpose datapath register with clear/load/increment control.
// Priority: clear > load > inc > hold. Increment wraps modulo 2^WIDTH.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high; forces the register to 0
//   i_clear  in   clear strobe
//   i_load   in   load strobe (takes i_d)
//   i_inc    in   increment strobe
//   i_d      in   load data
//   o_q      out  register value
// ----------------------------------------------------------------------------
module datapath_register
   import cpu_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic             i_inc,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // NOTE: sequential state is written with non-blocking (<=) assignments so
   // every register samples its inputs as they were before the clock edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_clear) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end else if (i_inc) begin
         r_q <= r_q + WIDTH'(1);
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/register_datapath.sv
// ----------------------------------------------------------------------------
// register_datapath
// Executes the control word issued each cycle by the CPU control unit:
// registers AR, PC, DR, AC, IR, TR, a common bus, the memory port and a
// registered ALU stage whose result feeds AC.
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   load_*/clear_*/inc_*         per-register strobes (IR: load only)
//   memory_read                  gates mem_rdata onto the bus (sel 7)
//   memory_write                 memory write request
//   bus_selectors[2:0]           bus source select (bus_sel_e)
//   alu_enable, alu_mode[2:0]    capture ALU result / operation (alu_mode_e)
//   mem_rdata                    memory read data (combinational on mem_addr)
//   mem_addr, mem_wdata, mem_we  memory port: AR, bus value, write enable
//   IR, AC_out, bus_value        register / bus observation
//   carry, zero                  E flag; AC == 0
//   write_collision              sticky: write requested while bus = memory
// ----------------------------------------------------------------------------
module register_datapath
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_AR,
   input  logic                  load_PC,
   input  logic                  load_DR,
   input  logic                  load_AC,
   input  logic                  load_IR,
   input  logic                  load_TR,
   input  logic                  clear_AR,
   input  logic                  clear_PC,
   input  logic                  clear_DR,
   input  logic                  clear_AC,
   input  logic                  clear_TR,
   input  logic                  inc_AR,
   input  logic                  inc_PC,
   input  logic                  inc_DR,
   input  logic                  inc_AC,
   input  logic                  inc_TR,
   input  logic                  memory_read,
   input  logic                  memory_write,
   input  logic [2:0]            bus_selectors,
   input  logic                  alu_enable,
   input  logic [2:0]            alu_mode,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] IR,
   output logic [DATA_WIDTH-1:0] AC_out,
   output logic [DATA_WIDTH-1:0] bus_value,
   output logic                  carry,
   output logic                  zero,
   output logic                  write_collision
);

   logic [ADDR_WIDTH-1:0] w_ar;
   logic [ADDR_WIDTH-1:0] w_pc;
   logic [DATA_WIDTH-1:0] w_dr;
   logic [DATA_WIDTH-1:0] w_ac;
   logic [DATA_WIDTH-1:0] w_tr;
   logic [DATA_WIDTH-1:0] w_bus;
   logic                  w_bus_is_mem;

   logic [DATA_WIDTH-1:0] r_ir;
   logic [DATA_WIDTH-1:0] r_alu_result;
   logic                  r_carry;
   logic                  r_write_collision;

   logic [DATA_WIDTH:0]   w_sum;
   logic [DATA_WIDTH:0]   w_diff;
   logic [DATA_WIDTH-1:0] w_alu_result;
   logic                  w_alu_carry;

   // ---------------------------------------------------------------- bus ---
   // NOTE: every combinational output gets a default before the case, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_bus = '0;
      case (bus_sel_e'(bus_selectors))
         BUS_NONE: w_bus = '0;
         BUS_AR:   w_bus = DATA_WIDTH'(w_ar);
         BUS_PC:   w_bus = DATA_WIDTH'(w_pc);
         BUS_DR:   w_bus = w_dr;
         BUS_AC:   w_bus = w_ac;
         BUS_IR:   w_bus = r_ir;
         BUS_TR:   w_bus = w_tr;
         BUS_MEM:  w_bus = memory_read ? mem_rdata : '0;
         default:  w_bus = '0;
      endcase
   end

   assign w_bus_is_mem = (bus_selectors == BUS_MEM);

   // ---------------------------------------------------------- registers ---
   datapath_register #(.WIDTH(ADDR_WIDTH)) u_ar (
      .clock(clock), .reset(reset),
      .i_clear(clear_AR), .i_load(load_AR), .i_inc(inc_AR),
      .i_d(ADDR_WIDTH'(w_bus)), .o_q(w_ar)
   );

   datapath_register #(.WIDTH(ADDR_WIDTH)) u_pc (
      .clock(clock), .reset(reset),
      .i_clear(clear_PC), .i_load(load_PC), .i_inc(inc_PC),
      .i_d(ADDR_WIDTH'(w_bus)), .o_q(w_pc)
   );

   datapath_register #(.WIDTH(DATA_WIDTH)) u_dr (
      .clock(clock), .reset(reset),
      .i_clear(clear_DR), .i_load(load_DR), .i_inc(inc_DR),
      .i_d(w_bus), .o_q(w_dr)
   );

   // AC loads from the ALU result register, never from the bus. A load in the
   // same cycle as an ALU capture therefore sees the previous result.
   datapath_register #(.WIDTH(DATA_WIDTH)) u_ac (
      .clock(clock), .reset(reset),
      .i_clear(clear_AC), .i_load(load_AC), .i_inc(inc_AC),
      .i_d(r_alu_result), .o_q(w_ac)
   );

   datapath_register #(.WIDTH(DATA_WIDTH)) u_tr (
      .clock(clock), .reset(reset),
      .i_clear(clear_TR), .i_load(load_TR), .i_inc(inc_TR),
      .i_d(w_bus), .o_q(w_tr)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ir <= '0;
      end else if (load_IR) begin
         r_ir <= w_bus;
      end
   end

   // ---------------------------------------------------------------- ALU ---
   assign w_sum  = {1'b0, w_ac} + {1'b0, w_dr};
   // Two's-complement subtract; the top bit is 1 when no borrow occurred.
   assign w_diff = {1'b0, w_ac} + {1'b0, ~w_dr} + (DATA_WIDTH+1)'(1);

   always_comb begin
      w_alu_result = r_alu_result;
      w_alu_carry  = r_carry;
      case (alu_mode_e'(alu_mode))
         ALU_AND:   w_alu_result = w_ac & w_dr;
         ALU_ADD: begin
            w_alu_result = w_sum[DATA_WIDTH-1:0];
            w_alu_carry  = w_sum[DATA_WIDTH];
         end
         ALU_SUB: begin
            w_alu_result = w_diff[DATA_WIDTH-1:0];
            w_alu_carry  = w_diff[DATA_WIDTH];
         end
         ALU_OR:    w_alu_result = w_ac | w_dr;
         ALU_XOR:   w_alu_result = w_ac ^ w_dr;
         ALU_STORE: w_alu_result = w_ac;
         ALU_LOAD:  w_alu_result = w_dr;
         ALU_NOT:   w_alu_result = ~w_ac;
         default:   w_alu_result = r_alu_result;
      endcase
   end

   // NOTE: there is no memory array here; every flop, including the ALU result
   // and sticky error flag, is reset so nothing powers up undefined.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_alu_result <= '0;
         r_carry      <= 1'b0;
      end else if (alu_enable) begin
         r_alu_result <= w_alu_result;
         r_carry      <= w_alu_carry;
      end
   end

   // ------------------------------------------------------- memory port ---
   // A write while the bus is sourced from memory would drive memory with its
   // own read data; it is suppressed and flagged until the next reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_write_collision <= 1'b0;
      end else if (memory_write && w_bus_is_mem) begin
         r_write_collision <= 1'b1;
      end
   end

   assign mem_we    = memory_write & ~reset & ~w_bus_is_mem;
   assign mem_addr  = w_ar;
   assign mem_wdata = w_bus;

   // ------------------------------------------------------------ outputs ---
   assign IR              = r_ir;
   assign AC_out          = w_ac;
   assign bus_value       = w_bus;
   assign carry           = r_carry;
   // Reported as 1 throughout a reset cycle, before AC has actually cleared.
   assign zero            = reset | (w_ac == '0);
   assign write_collision = r_write_collision;

endmodule
